operand_fetch: RTL and testbench

Decode-to-execute pipeline stage sitting directly downstream of the 16x32 register file. Each cycle it takes the two asynchronous read-port values for the decoded instruction and resolves data hazards:
- R15 reads are replaced with PC+8.
- Results from the execute and memory stages are forwarded over stale register data.
- A load-use bubble is inserted when forwarding cannot cover the hazard.

It registers the resolved operands for the execute stage, honours downstream hold and branch flush, and keeps a saturating load-use stall counter.

---
 rtl/operand_fetch.sv | 119 +++++++++++
 tb/tb_operand_fetch.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/operand_fetch.sv
// Operand fetch stage: resolves register hazards for the decoded instruction
// (R15 as PC+8, EX/MEM forwarding, load-use bubble) and registers the
// resolved operands for the execute stage.
module operand_fetch #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 4,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_pc,
  input  logic [ADDR_W-1:0] in_rn,
  input  logic [ADDR_W-1:0] in_rm,
  input  logic [ADDR_W-1:0] in_rd,
  input  logic              in_use_rn,
  input  logic              in_use_rm,
  input  logic              in_use_imm,
  input  logic [DATA_W-1:0] in_imm,
  input  logic              in_regwrite,
  input  logic              in_is_load,
  input  logic [DATA_W-1:0] rf_data1,
  input  logic [DATA_W-1:0] rf_data2,
  input  logic [DATA_W-1:0] ex_result,
  input  logic              mem_valid,
  input  logic              mem_regwrite,
  input  logic [ADDR_W-1:0] mem_rd,
  input  logic [DATA_W-1:0] mem_result,
  input  logic              hold,
  input  logic              flush,
  output logic              stall,
  output logic              ex_valid,
  output logic [DATA_W-1:0] ex_op_a,
  output logic [DATA_W-1:0] ex_op_b,
  output logic [ADDR_W-1:0] ex_rd,
  output logic              ex_regwrite,
  output logic              ex_is_load,
  output logic [CNT_W-1:0]  stall_count
);

  localparam logic [ADDR_W-1:0] PC_REG = ADDR_W'(15);

  logic [DATA_W-1:0] pc_plus8;
  logic [DATA_W-1:0] op_a;
  logic [DATA_W-1:0] op_b;
  logic [DATA_W-1:0] op_b_reg;
  logic              ex_fwd_ok;
  logic              mem_fwd_ok;
  logic              load_use;

  // Priority: PC read, then younger EX result, then MEM result, then regfile.
  function automatic logic [DATA_W-1:0] resolve(
    input logic [ADDR_W-1:0] src,
    input logic [DATA_W-1:0] rf_val,
    input logic [DATA_W-1:0] pc_val,
    input logic              ex_ok,
    input logic [ADDR_W-1:0] ex_dst,
    input logic [DATA_W-1:0] ex_val,
    input logic              mem_ok,
    input logic [ADDR_W-1:0] mem_dst,
    input logic [DATA_W-1:0] mem_val
  );
    logic [DATA_W-1:0] r;
    r = rf_val;
    if (src == PC_REG)                   r = pc_val;
    else if (ex_ok && (ex_dst == src))   r = ex_val;
    else if (mem_ok && (mem_dst == src)) r = mem_val;
    return r;
  endfunction

  // Operand resolution, load-use detection and the upstream stall.
  always_comb begin
    pc_plus8   = in_pc + DATA_W'(8);
    // A load's ALU result is only an address, so it is never forwarded from EX.
    ex_fwd_ok  = ex_valid & ex_regwrite & ~ex_is_load;
    mem_fwd_ok = mem_valid & mem_regwrite;
    op_a = resolve(in_rn, rf_data1, pc_plus8, ex_fwd_ok, ex_rd, ex_result,
                   mem_fwd_ok, mem_rd, mem_result);
    op_b_reg = resolve(in_rm, rf_data2, pc_plus8, ex_fwd_ok, ex_rd, ex_result,
                       mem_fwd_ok, mem_rd, mem_result);
    op_b = in_use_imm ? in_imm : op_b_reg;
    load_use = in_valid & ex_valid & ex_is_load & ex_regwrite & (ex_rd != PC_REG) &
               ((in_use_rn & (in_rn == ex_rd)) |
                (in_use_rm & ~in_use_imm & (in_rm == ex_rd)));
    stall = hold | (load_use & ~flush);
  end

  // Execute-stage register: reset > flush > hold > bubble > capture.
  always_ff @(posedge clk) begin
    if (reset) begin
      ex_valid    <= 1'b0;
      ex_op_a     <= '0;
      ex_op_b     <= '0;
      ex_rd       <= '0;
      ex_regwrite <= 1'b0;
      ex_is_load  <= 1'b0;
      stall_count <= '0;
    end else if (flush) begin
      ex_valid    <= 1'b0;
      ex_regwrite <= 1'b0;
      ex_is_load  <= 1'b0;
    end else if (hold) begin
      ex_valid    <= ex_valid;
    end else if (load_use) begin
      ex_valid    <= 1'b0;
      ex_regwrite <= 1'b0;
      ex_is_load  <= 1'b0;
      if (stall_count != {CNT_W{1'b1}}) stall_count <= stall_count + CNT_W'(1);
    end else begin
      ex_valid    <= in_valid;
      ex_op_a     <= op_a;
      ex_op_b     <= op_b;
      ex_rd       <= in_rd;
      ex_regwrite <= in_valid & in_regwrite;
      ex_is_load  <= in_valid & in_is_load;
    end
  end

endmodule

// File: tb/tb_operand_fetch.sv
// Scenario bench for operand_fetch: expected ex_* bundles are queued when a
// cycle's stimulus is driven and popped/compared after the capturing edge.
module tb_operand_fetch;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic [31:0] in_pc;
  logic [3:0]  in_rn, in_rm, in_rd;
  logic        in_use_rn, in_use_rm, in_use_imm;
  logic [31:0] in_imm;
  logic        in_regwrite, in_is_load;
  logic [31:0] rf_data1, rf_data2, ex_result;
  logic        mem_valid, mem_regwrite;
  logic [3:0]  mem_rd;
  logic [31:0] mem_result;
  logic        hold, flush;
  logic        stall, ex_valid, ex_regwrite, ex_is_load;
  logic [31:0] ex_op_a, ex_op_b;
  logic [3:0]  ex_rd;
  logic [15:0] stall_count;
  logic        stall2, ex_valid2, ex_regwrite2, ex_is_load2;
  logic [31:0] ex_op_a2, ex_op_b2;
  logic [3:0]  ex_rd2;
  logic [1:0]  stall_count2;

  typedef struct packed {
    logic        v;
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  rd;
    logic        rw;
    logic        ld;
  } exp_t;

  exp_t sb[$];
  exp_t e, got;
  int   total = 0;
  int   bad = 0;
  int   exp_cnt = 0;
  int   exp_cnt2 = 0;

  operand_fetch dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_pc(in_pc),
    .in_rn(in_rn), .in_rm(in_rm), .in_rd(in_rd), .in_use_rn(in_use_rn),
    .in_use_rm(in_use_rm), .in_use_imm(in_use_imm), .in_imm(in_imm),
    .in_regwrite(in_regwrite), .in_is_load(in_is_load), .rf_data1(rf_data1),
    .rf_data2(rf_data2), .ex_result(ex_result), .mem_valid(mem_valid),
    .mem_regwrite(mem_regwrite), .mem_rd(mem_rd), .mem_result(mem_result),
    .hold(hold), .flush(flush), .stall(stall), .ex_valid(ex_valid),
    .ex_op_a(ex_op_a), .ex_op_b(ex_op_b), .ex_rd(ex_rd),
    .ex_regwrite(ex_regwrite), .ex_is_load(ex_is_load), .stall_count(stall_count)
  );

  operand_fetch #(.CNT_W(2)) dut_sat (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_pc(in_pc),
    .in_rn(in_rn), .in_rm(in_rm), .in_rd(in_rd), .in_use_rn(in_use_rn),
    .in_use_rm(in_use_rm), .in_use_imm(in_use_imm), .in_imm(in_imm),
    .in_regwrite(in_regwrite), .in_is_load(in_is_load), .rf_data1(rf_data1),
    .rf_data2(rf_data2), .ex_result(ex_result), .mem_valid(mem_valid),
    .mem_regwrite(mem_regwrite), .mem_rd(mem_rd), .mem_result(mem_result),
    .hold(hold), .flush(flush), .stall(stall2), .ex_valid(ex_valid2),
    .ex_op_a(ex_op_a2), .ex_op_b(ex_op_b2), .ex_rd(ex_rd2),
    .ex_regwrite(ex_regwrite2), .ex_is_load(ex_is_load2), .stall_count(stall_count2)
  );

  // Free-running clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] pc, input logic [3:0] rn,
                       input logic [3:0] rm, input logic [3:0] rd, input logic urn,
                       input logic urm, input logic uimm, input logic [31:0] imm,
                       input logic rw, input logic ld, input logic [31:0] d1,
                       input logic [31:0] d2);
    in_valid = v; in_pc = pc; in_rn = rn; in_rm = rm; in_rd = rd;
    in_use_rn = urn; in_use_rm = urm; in_use_imm = uimm; in_imm = imm;
    in_regwrite = rw; in_is_load = ld; rf_data1 = d1; rf_data2 = d2;
  endtask

  task automatic test_reset();
    reset = 1'b1; hold = 1'b0; flush = 1'b0;
    mem_valid = 1'b0; mem_regwrite = 1'b0; mem_rd = 4'd0; mem_result = 32'd0;
    ex_result = 32'd0;
    drive(1, 32'h40, 1, 2, 3, 1, 1, 0, 32'h0, 1, 1, 32'hAAAA, 32'hBBBB);
    sb.push_back('0);
    tick(); tick();
    e = sb.pop_front();
    got = {ex_valid, ex_op_a, ex_op_b, ex_rd, ex_regwrite, ex_is_load};
    total++; if (got !== e) begin bad++; $display("FAIL reset_outputs got=%h exp=%h", got, e); end
    total++; if (stall_count !== 16'd0) begin bad++; $display("FAIL reset_count got=%0d exp=0", stall_count); end
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL reset_stall got=%b exp=0", stall); end
    reset = 1'b0;
  endtask

  task automatic test_forwarding();
    // ADD r1 enters EX.
    drive(1, 32'h40, 3, 4, 1, 1, 1, 0, 32'h0, 1, 0, 32'h11, 32'h22);
    sb.push_back('{1'b1, 32'h11, 32'h22, 4'd1, 1'b1, 1'b0});
    tick();
    e = sb.pop_front();
    got = {ex_valid, ex_op_a, ex_op_b, ex_rd, ex_regwrite, ex_is_load};
    total++; if (got !== e) begin bad++; $display("FAIL fwd_setup got=%h exp=%h", got, e); end
    // Reader of r1 while r1 is in EX.
    drive(1, 32'h44, 1, 5, 6, 1, 1, 0, 32'h0, 1, 0, 32'h9, 32'h33);
    ex_result = 32'h5;
    #1;
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL fwd_ex_stall got=%b exp=0", stall); end
    sb.push_back('{1'b1, 32'h5, 32'h33, 4'd6, 1'b1, 1'b0});
    tick();
    e = sb.pop_front();
    got = {ex_valid, ex_op_a, ex_op_b, ex_rd, ex_regwrite, ex_is_load};
    total++; if (got !== e) begin bad++; $display("FAIL fwd_ex got=%h exp=%h", got, e); end
    // r1 only in MEM; immediate operand B.
    drive(1, 32'h48, 1, 6, 7, 1, 1, 1, 32'h55, 1, 0, 32'h9, 32'h44);
    ex_result = 32'hDEAD;
    mem_valid = 1'b1; mem_regwrite = 1'b1; mem_rd = 4'd1; mem_result = 32'h7;
    sb.push_back('{1'b1, 32'h7, 32'h55, 4'd7, 1'b1, 1'b0});
    tick();
    e = sb.pop_front();
    got = {ex_valid, ex_op_a, ex_op_b, ex_rd, ex_regwrite, ex_is_load};
    total++; if (got !== e) begin bad++; $display("FAIL fwd_mem got=%h exp=%h", got, e); end
    // r7 in both EX and MEM: EX wins; invalid-free regwrite=0 instruction.
    drive(1, 32'h4C, 2, 7, 8, 1, 1, 0, 32'h0, 0, 0, 32'h12, 32'h99);
    ex_result = 32'hEE; mem_rd = 4'd7; mem_result = 32'h77;
    sb.push_back('{1'b1, 32'h12, 32'hEE, 4'd8, 1'b0, 1'b0});
    tick();
    e = sb.pop_front();
    got = {ex_valid, ex_op_a, ex_op_b, ex_rd, ex_regwrite, ex_is_load};
    total++; if (got !== e) begin bad++; $display("FAIL fwd_ex_over_mem got=%h exp=%h", got, e); end
    mem_valid = 1'b0; mem_regwrite = 1'b0;
  endtask

  task automatic test_r15();
    drive(1, 32'h80, 0, 0, 15, 1, 1, 0, 32'h0, 1, 0, 32'h1, 32'h2);
    sb.push_back('{1'b1, 32'h1, 32'h2, 4'd15, 1'b1, 1'b0});
    tick();
    e = sb.pop_front();
    got = {ex_valid, ex_op_a, ex_op_b, ex_rd, ex_regwrite, ex_is_load};
    total++; if (got !== e) begin bad++; $display("FAIL r15_setup got=%h exp=%h", got, e); end
    drive(1, 32'h100, 15, 15, 0, 1, 1, 0, 32'h0, 0, 0, 32'h111, 32'h222);
    ex_result = 32'hBAD;
    mem_valid = 1'b1; mem_regwrite = 1'b1; mem_rd = 4'd15; mem_result = 32'hCAFE;
    sb.push_back('{1'b1, 32'h108, 32'h108, 4'd0, 1'b0, 1'b0});
    tick();
    e = sb.pop_front();
    got = {ex_valid, ex_op_a, ex_op_b, ex_rd, ex_regwrite, ex_is_load};
    total++; if (got !== e) begin bad++; $display("FAIL r15_no_fwd got=%h exp=%h", got, e); end
    drive(1, 32'hFFFF_FFFC, 15, 0, 0, 1, 1, 0, 32'h0, 0, 0, 32'h0, 32'h3);
    mem_valid = 1'b0; mem_regwrite = 1'b0;
    sb.push_back('{1'b1, 32'h4, 32'h3, 4'd0, 1'b0, 1'b0});
    tick();
    e = sb.pop_front();
    got = {ex_valid, ex_op_a, ex_op_b, ex_rd, ex_regwrite, ex_is_load};
    total++; if (got !== e) begin bad++; $display("FAIL r15_wrap got=%h exp=%h", got, e); end
  endtask

  task automatic test_load_use();
    // LDR r2 enters EX.
    drive(1, 32'h200, 0, 0, 2, 1, 0, 1, 32'h4, 1, 1, 32'h1000, 32'h0);
    sb.push_back('{1'b1, 32'h1000, 32'h4, 4'd2, 1'b1, 1'b1});
    tick();
    e = sb.pop_front();
    got = {ex_valid, ex_op_a, ex_op_b, ex_rd, ex_regwrite, ex_is_load};
    total++; if (got !== e) begin bad++; $display("FAIL lu_load got=%h exp=%h", got, e); end
    // Consumer of r2 through rm.
    drive(1, 32'h204, 3, 2, 4, 1, 1, 0, 32'h0, 1, 0, 32'h30, 32'hBAD);
    ex_result = 32'h1004;
    #1;
    total++; if (stall !== 1'b1) begin bad++; $display("FAIL lu_stall got=%b exp=1", stall); end
    sb.push_back('{1'b0, 32'h1000, 32'h4, 4'd2, 1'b0, 1'b0});
    tick();
    exp_cnt++; exp_cnt2++;
    e = sb.pop_front();
    got = {ex_valid, ex_op_a, ex_op_b, ex_rd, ex_regwrite, ex_is_load};
    total++; if (got !== e) begin bad++; $display("FAIL lu_bubble got=%h exp=%h", got, e); end
    total++; if (stall_count !== 16'(exp_cnt)) begin bad++; $display("FAIL lu_count got=%0d exp=%0d", stall_count, exp_cnt); end
    // Load now in MEM: forwarded, stall released.
    mem_valid = 1'b1; mem_regwrite = 1'b1; mem_rd = 4'd2; mem_result = 32'h4242;
    #1;
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL lu_release got=%b exp=0", stall); end
    sb.push_back('{1'b1, 32'h30, 32'h4242, 4'd4, 1'b1, 1'b0});
    tick();
    e = sb.pop_front();
    got = {ex_valid, ex_op_a, ex_op_b, ex_rd, ex_regwrite, ex_is_load};
    total++; if (got !== e) begin bad++; $display("FAIL lu_mem_fwd got=%h exp=%h", got, e); end
    mem_valid = 1'b0; mem_regwrite = 1'b0;
    // LDR r5, then an instruction naming r5 in unused source fields.
    drive(1, 32'h208, 1, 0, 5, 1, 0, 1, 32'h0, 1, 1, 32'h10, 32'h0);
    sb.push_back('{1'b1, 32'h10, 32'h0, 4'd5, 1'b1, 1'b1});
    tick();
    e = sb.pop_front();
    got = {ex_valid, ex_op_a, ex_op_b, ex_rd, ex_regwrite, ex_is_load};
    total++; if (got !== e) begin bad++; $display("FAIL lu_load2 got=%h exp=%h", got, e); end
    drive(1, 32'h20C, 5, 5, 6, 0, 0, 0, 32'h0, 0, 0, 32'h51, 32'h52);
    #1;
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL lu_unused_stall got=%b exp=0", stall); end
    sb.push_back('{1'b1, 32'h51, 32'h52, 4'd6, 1'b0, 1'b0});
    tick();
    e = sb.pop_front();
    got = {ex_valid, ex_op_a, ex_op_b, ex_rd, ex_regwrite, ex_is_load};
    total++; if (got !== e) begin bad++; $display("FAIL lu_unused got=%h exp=%h", got, e); end
  endtask

  task automatic test_hold();
    hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(1, $urandom, 4'($urandom), 4'($urandom), 4'($urandom), 1, 1, 1'($urandom),
            $urandom, 1, 1'($urandom), $urandom, $urandom);
      ex_result = $urandom;
      #1;
      total++; if (stall !== 1'b1) begin bad++; $display("FAIL hold_stall[%0d] got=%b exp=1", i, stall); end
      sb.push_back('{1'b1, 32'h51, 32'h52, 4'd6, 1'b0, 1'b0});
      tick();
      e = sb.pop_front();
      got = {ex_valid, ex_op_a, ex_op_b, ex_rd, ex_regwrite, ex_is_load};
      total++; if (got !== e) begin bad++; $display("FAIL hold_keep[%0d] got=%h exp=%h", i, got, e); end
    end
    hold = 1'b0;
    total++; if (stall_count !== 16'(exp_cnt)) begin bad++; $display("FAIL hold_count got=%0d exp=%0d", stall_count, exp_cnt); end
  endtask

  task automatic test_flush();
    for (int k = 0; k < 2; k++) begin
      hold = 1'b0; flush = 1'b0;
      drive(1, 32'h300, 0, 0, 2, 1, 0, 1, 32'h8, 1, 1, 32'h200, 32'h0);
      sb.push_back('{1'b1, 32'h200, 32'h8, 4'd2, 1'b1, 1'b1});
      tick();
      e = sb.pop_front();
      got = {ex_valid, ex_op_a, ex_op_b, ex_rd, ex_regwrite, ex_is_load};
      total++; if (got !== e) begin bad++; $display("FAIL flush_load[%0d] got=%h exp=%h", k, got, e); end
      // Load-use with flush; second pass also holds.
      drive(1, 32'h304, 2, 0, 3, 1, 0, 1, 32'h1, 1, 0, 32'h5, 32'h0);
      flush = 1'b1; hold = (k == 1);
      #1;
      total++; if (stall !== (k == 1)) begin bad++; $display("FAIL flush_stall[%0d] got=%b exp=%b", k, stall, (k == 1)); end
      sb.push_back('{1'b0, 32'h200, 32'h8, 4'd2, 1'b0, 1'b0});
      tick();
      e = sb.pop_front();
      got = {ex_valid, ex_op_a, ex_op_b, ex_rd, ex_regwrite, ex_is_load};
      total++; if (got !== e) begin bad++; $display("FAIL flush_kill[%0d] got=%h exp=%h", k, got, e); end
      total++; if (stall_count !== 16'(exp_cnt)) begin bad++; $display("FAIL flush_count[%0d] got=%0d exp=%0d", k, stall_count, exp_cnt); end
    end
    hold = 1'b0; flush = 1'b0;
  endtask

  task automatic test_reset_mid_stall();
    drive(1, 32'h400, 0, 0, 2, 1, 0, 1, 32'h0, 1, 1, 32'h7, 32'h0);
    sb.push_back('{1'b1, 32'h7, 32'h0, 4'd2, 1'b1, 1'b1});
    tick();
    e = sb.pop_front();
    got = {ex_valid, ex_op_a, ex_op_b, ex_rd, ex_regwrite, ex_is_load};
    total++; if (got !== e) begin bad++; $display("FAIL rst_mid_load got=%h exp=%h", got, e); end
    drive(1, 32'h404, 2, 0, 3, 1, 0, 1, 32'h0, 1, 0, 32'h5, 32'h0);
    reset = 1'b1;
    sb.push_back('0);
    tick();
    exp_cnt = 0; exp_cnt2 = 0;
    e = sb.pop_front();
    got = {ex_valid, ex_op_a, ex_op_b, ex_rd, ex_regwrite, ex_is_load};
    total++; if (got !== e) begin bad++; $display("FAIL rst_mid_clear got=%h exp=%h", got, e); end
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL rst_mid_stall got=%b exp=0", stall); end
    reset = 1'b0;
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 5; i++) begin
      drive(1, 32'h500, 0, 0, 2, 1, 0, 1, 32'h0, 1, 1, 32'(i), 32'h0);
      sb.push_back('{1'b1, 32'(i), 32'h0, 4'd2, 1'b1, 1'b1});
      tick();
      e = sb.pop_front();
      got = {ex_valid, ex_op_a, ex_op_b, ex_rd, ex_regwrite, ex_is_load};
      total++; if (got !== e) begin bad++; $display("FAIL sat_load[%0d] got=%h exp=%h", i, got, e); end
      drive(1, 32'h504, 2, 0, 3, 1, 0, 1, 32'h0, 1, 0, 32'h5, 32'h0);
      #1;
      total++; if (stall !== 1'b1) begin bad++; $display("FAIL sat_stall[%0d] got=%b exp=1", i, stall); end
      sb.push_back('{1'b0, 32'(i), 32'h0, 4'd2, 1'b0, 1'b0});
      tick();
      exp_cnt++;
      if (exp_cnt2 < 3) exp_cnt2++;
      e = sb.pop_front();
      got = {ex_valid, ex_op_a, ex_op_b, ex_rd, ex_regwrite, ex_is_load};
      total++; if (got !== e) begin bad++; $display("FAIL sat_bubble[%0d] got=%h exp=%h", i, got, e); end
      total++; if (stall_count !== 16'(exp_cnt)) begin bad++; $display("FAIL sat_count16[%0d] got=%0d exp=%0d", i, stall_count, exp_cnt); end
      total++; if (stall_count2 !== 2'(exp_cnt2)) begin bad++; $display("FAIL sat_count2[%0d] got=%0d exp=%0d", i, stall_count2, exp_cnt2); end
    end
    total++; if (stall_count2 !== 2'd3) begin bad++; $display("FAIL sat_final got=%0d exp=3", stall_count2); end
  endtask

  // Scenario sequence.
  initial begin
    test_reset();
    test_forwarding();
    test_r15();
    test_load_use();
    test_hold();
    test_flush();
    test_reset_mid_stall();
    test_saturation();
    total++; if (sb.size() != 0) begin bad++; $display("FAIL scoreboard_left got=%0d exp=0", sb.size()); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
